// File: rtl/sync_debounce_pkg.sv
// Shared constants and helpers for the multi-channel synchronizer/debouncer.
package sync_debounce_pkg;

    localparam int DEF_WIDTH    = 4;
    localparam int DEF_STAGES   = 3;
    localparam int DEF_DEBOUNCE = 4;

    // Counter width able to hold 0..DEBOUNCE-1, never narrower than one bit.
    function automatic int cnt_width(input int debounce);
        int w;
        w = $clog2(debounce + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_debounce_ch.sv
// One channel: STAGES-deep synchronizer, stability counter, debounced level
// and registered rise/fall strobes.
module sync_debounce_ch
    import sync_debounce_pkg::*;
#(
    parameter int   STAGES   = DEF_STAGES,
    parameter int   DEBOUNCE = DEF_DEBOUNCE,
    parameter logic INIT_BIT = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_ext,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int            CW       = cnt_width(DEBOUNCE);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    logic [STAGES-1:0] r_sync;
    logic [CW-1:0]     r_cnt;
    logic              r_level;
    logic              r_rise;
    logic              r_fall;
    logic              w_s;

    // Synchronizer chain: raw input enters the MSB and shifts toward bit 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= {STAGES{INIT_BIT}};
        end else begin
            r_sync <= {i_ext, r_sync[STAGES-1:1]};
        end
    end

    assign w_s = r_sync[0];

    // Stability filter: accept a new level after DEBOUNCE consecutive
    // mismatching samples; any matching sample clears the partial count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_level <= INIT_BIT;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else if (w_s == r_level) begin
            r_cnt  <= '0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_level <= w_s;
            r_rise  <= w_s;
            r_fall  <= ~w_s;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/sync_debounce.sv
// WIDTH independent synchronize-and-debounce channels sharing clock and reset.
module sync_debounce
    import sync_debounce_pkg::*;
#(
    parameter int               WIDTH    = DEF_WIDTH,
    parameter int               STAGES   = DEF_STAGES,
    parameter int               DEBOUNCE = DEF_DEBOUNCE,
    parameter logic [WIDTH-1:0] INIT     = {WIDTH{1'b0}}
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_ext,
    output logic [WIDTH-1:0] o_level,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall
);

    // One channel instance per input bit; channels share nothing else.
    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        sync_debounce_ch #(
            .STAGES   (STAGES),
            .DEBOUNCE (DEBOUNCE),
            .INIT_BIT (INIT[g])
        ) u_ch (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_ext   (i_ext[g]),
            .o_level (o_level[g]),
            .o_rise  (o_rise[g]),
            .o_fall  (o_fall[g])
        );
    end

endmodule

// File: tb/tb_sync_debounce.sv
// Bench for sync_debounce: table-driven vectors, hand-written corner cases,
// and randomized stimulus checked against a sliding-window reference model.
module tb_sync_debounce;

    localparam int         W    = 4;
    localparam int         ST   = 3;
    localparam int         DB   = 4;
    localparam logic [W-1:0] INIT = 4'b0000;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] ext;
    logic [W-1:0] level;
    logic [W-1:0] rise;
    logic [W-1:0] fall;

    int n_checks;
    int n_errors;

    sync_debounce #(
        .WIDTH    (W),
        .STAGES   (ST),
        .DEBOUNCE (DB),
        .INIT     (INIT)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_ext   (ext),
        .o_level (level),
        .o_rise  (rise),
        .o_fall  (fall)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: history of captured inputs, newest first. The
    // synchronized sample seen at an edge is the input captured ST edges
    // earlier; a new level is accepted once the last DB such samples all
    // differ from the current level.
    logic [W-1:0] hist[$];
    logic [W-1:0] m_level;
    logic [W-1:0] m_rise;
    logic [W-1:0] m_fall;

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < ST + DB; i++) hist.push_front(INIT);
        m_level = INIT;
        m_rise  = '0;
        m_fall  = '0;
    endtask

    task automatic model_edge(input logic [W-1:0] e);
        logic all_diff;
        logic [W-1:0] nl;
        hist.push_front(e);
        nl = m_level;
        for (int b = 0; b < W; b++) begin
            all_diff = 1'b1;
            for (int i = ST; i < ST + DB; i++)
                if (hist[i][b] == m_level[b]) all_diff = 1'b0;
            if (all_diff) nl[b] = ~m_level[b];
        end
        m_rise  = nl & ~m_level;
        m_fall  = ~nl & m_level;
        m_level = nl;
        void'(hist.pop_back());
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Driver: called at a falling edge; applies input, takes one rising
    // edge, checks against the model, and returns at the next falling edge.
    task automatic step(input logic [W-1:0] e);
        ext = e;
        @(posedge clk);
        model_edge(e);
        #1;
        check("mdl_level", level, m_level);
        check("mdl_rise",  rise,  m_rise);
        check("mdl_fall",  fall,  m_fall);
        @(negedge clk);
    endtask

    // Assert reset between edges and confirm outputs clear with no clock.
    task automatic reset_mid_clock(input string tag);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check({tag, "_lvl"},  level, INIT);
        check({tag, "_rise"}, rise,  '0);
        check({tag, "_fall"}, fall,  '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [W-1:0] ext;
        logic [W-1:0] lvl;
        logic [W-1:0] rs;
        logic [W-1:0] fl;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int n, input logic [W-1:0] e, input logic [W-1:0] l,
                       input logic [W-1:0] r, input logic [W-1:0] f);
        vec_t v;
        v.ext = e; v.lvl = l; v.rs = r; v.fl = f;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    logic [W-1:0] cur;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        ext   = 4'hF;
        model_reset();
        #1;
        check("rst_level", level, INIT);
        check("rst_rise",  rise,  '0);
        check("rst_fall",  fall,  '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Quiet period at INIT: no strobes, level stays 0.
        for (int i = 0; i < 20; i++) begin
            step(4'h0);
            check("quiet_lvl",  level, 4'h0);
            check("quiet_strb", rise | fall, 4'h0);
        end

        // Clean rising edge on bit 0.
        add(6, 4'h1, 4'h0, 4'h0, 4'h0);
        add(1, 4'h1, 4'h1, 4'h1, 4'h0);
        add(1, 4'h1, 4'h1, 4'h0, 4'h0);
        // Glitches on bit 1: 3 high, 1 low, 3 high, then low.
        add(3, 4'h3, 4'h1, 4'h0, 4'h0);
        add(1, 4'h1, 4'h1, 4'h0, 4'h0);
        add(3, 4'h3, 4'h1, 4'h0, 4'h0);
        add(4, 4'h1, 4'h1, 4'h0, 4'h0);
        // A 4-cycle hold on bit 1 is accepted, then its release falls.
        add(4, 4'h3, 4'h1, 4'h0, 4'h0);
        add(2, 4'h1, 4'h1, 4'h0, 4'h0);
        add(1, 4'h1, 4'h3, 4'h2, 4'h0);
        add(3, 4'h1, 4'h3, 4'h0, 4'h0);
        add(1, 4'h1, 4'h1, 4'h0, 4'h2);
        add(1, 4'h1, 4'h1, 4'h0, 4'h0);
        // Bit 2 up, then dropped for 10 cycles.
        add(6, 4'h5, 4'h1, 4'h0, 4'h0);
        add(1, 4'h5, 4'h5, 4'h4, 4'h0);
        add(1, 4'h5, 4'h5, 4'h0, 4'h0);
        add(6, 4'h1, 4'h5, 4'h0, 4'h0);
        add(1, 4'h1, 4'h1, 4'h0, 4'h4);
        add(3, 4'h1, 4'h1, 4'h0, 4'h0);
        // Drain to zero, then all bits rise together.
        add(6, 4'h0, 4'h1, 4'h0, 4'h0);
        add(1, 4'h0, 4'h0, 4'h0, 4'h1);
        add(1, 4'h0, 4'h0, 4'h0, 4'h0);
        add(6, 4'hF, 4'h0, 4'h0, 4'h0);
        add(1, 4'hF, 4'hF, 4'hF, 4'h0);
        add(1, 4'hF, 4'hF, 4'h0, 4'h0);

        foreach (tbl[i]) begin
            step(tbl[i].ext);
            check($sformatf("tbl%0d_lvl", i),  level, tbl[i].lvl);
            check($sformatf("tbl%0d_rise", i), rise,  tbl[i].rs);
            check($sformatf("tbl%0d_fall", i), fall,  tbl[i].fl);
        end

        // Asynchronous reset with all levels high.
        reset_mid_clock("rst_async");
        for (int i = 0; i < 20; i++) begin
            step(4'h0);
            check("post_rst_lvl",  level, 4'h0);
            check("post_rst_strb", rise | fall, 4'h0);
        end

        // Reset in the middle of a count on bit 3, then a full re-latency.
        for (int i = 0; i < 5; i++) step(4'h8);
        reset_mid_clock("rst_mid");
        for (int i = 1; i <= 7; i++) begin
            step(4'h8);
            check("rel_lvl",  level, (i == 7) ? 4'h8 : 4'h0);
            check("rel_rise", rise,  (i == 7) ? 4'h8 : 4'h0);
        end
        step(4'h8);
        check("rel_rise_clr", rise, 4'h0);

        // Randomized bit flips with occasional resets.
        cur = 4'h8;
        for (int i = 0; i < 800; i++) begin
            for (int b = 0; b < W; b++)
                if ($urandom_range(0, 5) == 0) cur[b] = ~cur[b];
            if ($urandom_range(0, 299) == 0) begin
                reset_mid_clock("rnd_rst");
            end
            step(cur);
            check("rnd_excl", rise & fall, 4'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
